// File: rtl/video_mode_pkg.sv
// Shared mode/FSM encodings plus the mode-transition and mode-decode rules for the video path.
package video_mode_pkg;

  typedef enum logic [2:0] {
    ModeNormal = 3'd0,
    ModeRed    = 3'd1,
    ModeGreen  = 3'd2,
    ModeBlue   = 3'd3,
    ModeGscale = 3'd4,
    ModeZoom2  = 3'd5,
    ModeZoom3  = 3'd6,
    ModeZoom4  = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    StStable,
    StPending,
    StFlush
  } seq_state_e;

  typedef struct packed {
    logic [2:0] chan_mask;
    logic       gray_en;
    logic [1:0] zoom;
  } mode_decode_t;

  // Bit positions inside the debounced sw[9:4] slice.
  localparam int unsigned SwGray = 0;
  localparam int unsigned SwB    = 1;
  localparam int unsigned SwG    = 2;
  localparam int unsigned SwR    = 3;

  // One step per commit: every non-NORMAL mode can only fall back to NORMAL.
  function automatic mode_e next_mode(input mode_e mode, input logic [5:0] sw_db);
    logic [1:0] zsel;
    zsel = sw_db[5:4];
    next_mode = mode;
    unique case (mode)
      ModeNormal: begin
        if (zsel == 2'b11)     next_mode = ModeZoom4;
        else if (zsel == 2'b10) next_mode = ModeZoom3;
        else if (zsel == 2'b01) next_mode = ModeZoom2;
        else if (sw_db[SwGray]) next_mode = ModeGscale;
        else if (sw_db[SwB])    next_mode = ModeBlue;
        else if (sw_db[SwG])    next_mode = ModeGreen;
        else if (sw_db[SwR])    next_mode = ModeRed;
        else                    next_mode = ModeNormal;
      end
      ModeRed:    next_mode = sw_db[SwR]    ? ModeRed    : ModeNormal;
      ModeGreen:  next_mode = sw_db[SwG]    ? ModeGreen  : ModeNormal;
      ModeBlue:   next_mode = sw_db[SwB]    ? ModeBlue   : ModeNormal;
      ModeGscale: next_mode = sw_db[SwGray] ? ModeGscale : ModeNormal;
      ModeZoom2, ModeZoom3, ModeZoom4: next_mode = (zsel == 2'b00) ? ModeNormal : mode;
      default:    next_mode = ModeNormal;
    endcase
  endfunction

  function automatic mode_decode_t decode(input mode_e mode);
    decode = '{chan_mask: 3'b111, gray_en: 1'b0, zoom: 2'd0};
    unique case (mode)
      ModeRed:    decode.chan_mask = 3'b100;
      ModeGreen:  decode.chan_mask = 3'b010;
      ModeBlue:   decode.chan_mask = 3'b001;
      ModeGscale: decode.gray_en   = 1'b1;
      ModeZoom2:  decode.zoom      = 2'd1;
      ModeZoom3:  decode.zoom      = 2'd2;
      ModeZoom4:  decode.zoom      = 2'd3;
      default:    decode.chan_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Multi-stage synchroniser followed by an independent debounce counter per bit.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_db_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][CntW-1:0]        cnt_q;
  logic [WIDTH-1:0]                  db_q;
  logic [WIDTH-1:0]                  synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign sw_db_o = db_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= sw_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // A bit flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any
  // agreement in between clears its count.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (synced[i] != db_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            db_q[i]  <= synced[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/video_mode_sequencer.sv
// Owns the committed video mode: changes are committed only on frame_start and followed by a
// fixed-length pipeline flush so no frame mixes two modes.
module video_mode_sequencer
  import video_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FLUSH_CYCLES    = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sw,
  input  logic       frame_start,
  output logic [2:0] mode,
  output logic [1:0] zoom,
  output logic [2:0] chan_mask,
  output logic       gray_en,
  output logic       pipe_flush,
  output logic       mode_valid
);

  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);

  logic [5:0]        sw_db;
  mode_e             target;
  seq_state_e        state_q;
  mode_e             mode_q;
  mode_decode_t      dec_q;
  logic              flush_q;
  logic              valid_q;
  logic [FlushW-1:0] cnt_q;
  logic              unused_sw;

  assign unused_sw = ^sw[3:0];

  switch_debouncer #(
    .WIDTH          (6),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_switch_debouncer (
    .clk    (clk),
    .rst    (rst),
    .sw_i   (sw[9:4]),
    .sw_db_o(sw_db)
  );

  assign target = next_mode(mode_q, sw_db);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStable;
      mode_q  <= ModeNormal;
      dec_q   <= decode(ModeNormal);
      flush_q <= 1'b0;
      valid_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StStable: begin
          if (target != mode_q) begin
            state_q <= StPending;
            valid_q <= 1'b0;
          end
        end
        StPending: begin
          if (target == mode_q) begin
            state_q <= StStable;
            valid_q <= 1'b1;
          end else if (frame_start) begin
            mode_q  <= target;
            dec_q   <= decode(target);
            flush_q <= 1'b1;
            cnt_q   <= FlushW'(FLUSH_CYCLES - 1);
            state_q <= StFlush;
          end
        end
        StFlush: begin
          // frame_start is deliberately ignored here; mode stays frozen until the flush drains.
          if (cnt_q == '0) begin
            flush_q <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StStable;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StStable;
      endcase
    end
  end

  assign mode       = mode_q;
  assign zoom       = dec_q.zoom;
  assign chan_mask  = dec_q.chan_mask;
  assign gray_en    = dec_q.gray_en;
  assign pipe_flush = flush_q;
  assign mode_valid = valid_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Scoreboard bench: expected commits are queued by the stimulus, a negedge monitor checks each flush.
module tb_video_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw = '0;
  logic       frame_start = 1'b0;
  logic [2:0] mode;
  logic [1:0] zoom;
  logic [2:0] chan_mask;
  logic       gray_en;
  logic       pipe_flush;
  logic       mode_valid;

  int errors = 0;
  int checks = 0;

  // Expected commit: {mode, chan_mask, gray_en, zoom}
  logic [8:0] exp_q[$];

  video_mode_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .FLUSH_CYCLES   (4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .frame_start(frame_start),
    .mode       (mode),
    .zoom       (zoom),
    .chan_mask  (chan_mask),
    .gray_en    (gray_en),
    .pipe_flush (pipe_flush),
    .mode_valid (mode_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, 32'(mode), 32'd0);
    chk({tag, "_chan"}, 32'(chan_mask), 32'h7);
    chk({tag, "_zoom"}, 32'(zoom), 32'd0);
    chk({tag, "_gray"}, 32'(gray_en), 32'd0);
    chk({tag, "_flush"}, 32'(pipe_flush), 32'd0);
    chk({tag, "_valid"}, 32'(mode_valid), 32'd1);
  endtask

  // Monitor: every rising pipe_flush is a commit; pop and compare, then measure flush width.
  logic flush_prev = 1'b0;
  int   flush_len = 0;
  always @(negedge clk) begin
    if (rst) begin
      flush_prev = 1'b0;
      flush_len  = 0;
    end else begin
      if (pipe_flush && !flush_prev) begin
        flush_len = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got mode %0d expected no commit", mode);
        end else begin
          chk("commit", 32'({mode, chan_mask, gray_en, zoom}), 32'(exp_q.pop_front()));
        end
      end else if (pipe_flush) begin
        flush_len++;
      end else if (flush_prev) begin
        chk("flush_len", 32'(flush_len), 32'd4);
      end
      flush_prev = pipe_flush;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic valid_dropped;

    // 1: reset and idle
    tick(3);
    chk_reset_vals("rst_held");
    rst = 1'b0;
    tick(20);
    chk_reset_vals("idle");

    // 3: bouncing sw[7] never debounces
    valid_dropped = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sw[7] = ~sw[7];
      tick(); valid_dropped |= ~mode_valid;
      tick(); valid_dropped |= ~mode_valid;
    end
    for (int i = 0; i < 15; i++) begin
      tick(); valid_dropped |= ~mode_valid;
    end
    chk("bounce_valid_dropped", 32'(valid_dropped), 32'd0);
    pulse_frame();
    tick(6);
    chk("bounce_mode", 32'(mode), 32'd0);

    // 2: sw[7] held -> RED, mode_valid falls 7 cycles after the sw edge
    sw[7] = 1'b1;
    tick(6);
    chk("red_valid_at6", 32'(mode_valid), 32'd1);
    tick();
    chk("red_valid_at7", 32'(mode_valid), 32'd0);
    tick(12);
    exp_q.push_back({3'b001, 3'b100, 1'b0, 2'd0});
    pulse_frame();
    chk("red_mode_at_edge", 32'(mode), 32'd1);
    chk("red_flush_at_edge", 32'(pipe_flush), 32'd1);
    tick(6);
    chk("red_valid_after", 32'(mode_valid), 32'd1);

    // 4: RED -> GREEN takes two commits via NORMAL
    sw[7] = 1'b0;
    sw[6] = 1'b1;
    tick(10);
    exp_q.push_back({3'b000, 3'b111, 1'b0, 2'd0});
    pulse_frame();
    tick(10);
    chk("via_normal_valid", 32'(mode_valid), 32'd0);
    exp_q.push_back({3'b010, 3'b010, 1'b0, 2'd0});
    pulse_frame();
    tick(6);
    chk("green_chan", 32'(chan_mask), 32'h2);

    // 5: back to NORMAL, then zoom=11 + gray -> ZOOM4 wins; zoom 01 holds ZOOM4
    sw[6] = 1'b0;
    tick(10);
    exp_q.push_back({3'b000, 3'b111, 1'b0, 2'd0});
    pulse_frame();
    tick(6);
    sw[9:8] = 2'b11;
    sw[4]   = 1'b1;
    tick(10);
    exp_q.push_back({3'b111, 3'b111, 1'b0, 2'd3});
    pulse_frame();
    tick(6);
    sw[9:8] = 2'b01;
    tick(15);
    chk("zoom_hold_valid", 32'(mode_valid), 32'd1);
    pulse_frame();
    tick(6);
    chk("zoom_hold_mode", 32'(mode), 32'd7);
    chk("zoom_hold_zoom", 32'(zoom), 32'd3);

    // 6: frame_start during flush is ignored; reset in PENDING restores everything
    sw[9:8] = 2'b00;
    tick(10);
    exp_q.push_back({3'b000, 3'b111, 1'b0, 2'd0});
    pulse_frame();
    pulse_frame();
    tick(8);
    chk("flush_fs_mode", 32'(mode), 32'd0);
    chk("pending_valid", 32'(mode_valid), 32'd0);
    chk("pending_flush", 32'(pipe_flush), 32'd0);
    rst = 1'b1;
    sw  = '0;
    tick();
    chk_reset_vals("rst_pending");
    rst = 1'b0;
    tick(20);
    chk_reset_vals("post_rst_idle");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
